// File: rtl/zjh_cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
// Holds the FSM state type, the cascade seed and the nibble-select helper.
package zjh_cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Cascade order is {gt, lt, eq}. Seeding with "equal" lets the first nibble decide alone.
  localparam logic [2:0] CASC_INIT = 3'b001;

  // Upper bound on operand width accepted by nib_sel; callers zero-extend to this width.
  localparam int MAX_WIDTH = 256;

  function automatic logic [3:0] nib_sel(input logic [MAX_WIDTH-1:0] word,
                                         input int unsigned          idx);
    return word[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/zjh_74HC85.sv
// 4-bit magnitude comparator with cascade inputs, modelled on the 74HC85.
// Purely combinational; the serial top feeds it one nibble per clock.
module zjh_74HC85 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_agb,
  input  logic       i_asb,
  input  logic       i_aeb,
  output logic       o_agb,
  output logic       o_asb,
  output logic       o_aeb
);

  logic w_gt_nib;
  logic w_lt_nib;
  logic w_eq_nib;

  assign w_gt_nib = (i_a > i_b);
  assign w_lt_nib = (i_a < i_b);
  assign w_eq_nib = (i_a == i_b);

  // An equal nibble passes the lower-significance verdict through.
  assign o_agb = w_gt_nib | (w_eq_nib & ~i_aeb & ~i_asb);
  assign o_asb = w_lt_nib | (w_eq_nib & ~i_aeb & ~i_agb);
  assign o_aeb = w_eq_nib & i_aeb;

endmodule

// File: rtl/zjh_serial_mag_cmp.sv
// Serial WIDTH-bit magnitude comparator: one nibble per clock, LSB nibble first,
// through a single 74HC85 whose outputs are registered back into its cascade inputs.
module zjh_serial_mag_cmp
  import zjh_cmp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             alb,
  output logic             aeb
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = $clog2(NIB);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    SIGNED ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_casc;
  logic             r_done;
  logic [2:0]       r_res;

  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic             w_gt;
  logic             w_lt;
  logic             w_eq;

  // FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start)  w_next = RUN;
      RUN:  if (w_last) w_next = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    busy     = 1'b0;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: w_accept = start;
      RUN: begin
        busy   = 1'b1;
        w_last = (r_cnt == LAST_CNT);
      end
    endcase
  end

  // Operand registers: pure datapath, only ever read after a load.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; the FSM guarantees r_a/r_b are loaded before they are used.
    if (w_accept) begin
      r_a <= a ^ SIGN_MASK;
      r_b <= b ^ SIGN_MASK;
    end
  end

  // Counter, cascade and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_casc <= CASC_INIT;
      r_done <= 1'b0;
      r_res  <= 3'b000;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_cnt  <= '0;
        r_casc <= CASC_INIT;
      end else if (busy) begin
        r_casc <= {w_gt, w_lt, w_eq};
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) r_res <= {w_gt, w_lt, w_eq};
    end
  end

  assign w_nib_a = nib_sel(MAX_WIDTH'(r_a), int'(r_cnt));
  assign w_nib_b = nib_sel(MAX_WIDTH'(r_b), int'(r_cnt));

  zjh_74HC85 u_cmp (
    .i_a   (w_nib_a),
    .i_b   (w_nib_b),
    .i_agb (r_casc[2]),
    .i_asb (r_casc[1]),
    .i_aeb (r_casc[0]),
    .o_agb (w_gt),
    .o_asb (w_lt),
    .o_aeb (w_eq)
  );

  assign done = r_done;
  assign agb  = r_res[2];
  assign alb  = r_res[1];
  assign aeb  = r_res[0];

  a_result_onehot : assert property (@(posedge clk) disable iff (rst)
    r_done |-> $onehot(r_res));

endmodule
